// File: rtl/rgb2ycbcr_csc_if.sv
// Video pixel path and shadow-register port of the colour-space converter.
// The slave modport is the converter side; the master modport is the source/host side.
interface rgb2ycbcr_csc_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 18
);
  logic                  de_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic [3*DATA_W-1:0]   pixel_in;
  logic                  de_out;
  logic                  hsync_out;
  logic                  vsync_out;
  logic [3*DATA_W-1:0]   pixel_out;
  logic                  cfg_we;
  logic [3:0]            cfg_addr;
  logic [COEF_W-1:0]     cfg_data;
  logic                  cfg_pending;

  modport slave (
    input  de_in, hsync_in, vsync_in, pixel_in, cfg_we, cfg_addr, cfg_data,
    output de_out, hsync_out, vsync_out, pixel_out, cfg_pending
  );

  modport master (
    output de_in, hsync_in, vsync_in, pixel_in, cfg_we, cfg_addr, cfg_data,
    input  de_out, hsync_out, vsync_out, pixel_out, cfg_pending
  );
endinterface

// File: rtl/rgb2ycbcr_csc.sv
// Programmable 3x3 RGB -> YCbCr converter with per-channel offset, rounding and clamping.
// Shadow coefficient bank is copied to the live bank only on a vsync rising edge.
module rgb2ycbcr_csc #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  rgb2ycbcr_csc_if.slave  bus
);
  localparam int PIX_W  = 3 * DATA_W;
  localparam int OFS_W  = DATA_W + 2;
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

  function automatic logic signed [COEF_W-1:0] dflt_coef(input int idx);
    case (idx)
      0: return COEF_W'(19595);
      1: return COEF_W'(38470);
      2: return COEF_W'(7471);
      3: return COEF_W'(-11059);
      4: return COEF_W'(-21709);
      5: return COEF_W'(32768);
      6: return COEF_W'(32768);
      7: return COEF_W'(-27439);
      8: return COEF_W'(-5329);
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [OFS_W-1:0] dflt_ofs(input int ch);
    return (ch == 0) ? '0 : OFS_W'(128 << (DATA_W - 8));
  endfunction

  function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] sum);
    return sum + RND;
  endfunction

  function automatic logic [DATA_W-1:0] sat_pix(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_W;
    if (sh < 0)            return '0;
    else if (sh > PIX_MAX) return '1;
    else                   return sh[DATA_W-1:0];
  endfunction

  logic signed [COEF_W-1:0] coef_sh  [9];
  logic signed [COEF_W-1:0] coef_act [9];
  logic signed [COEF_W-1:0] coef_nx  [9];
  logic signed [OFS_W-1:0]  ofs_sh   [3];
  logic signed [OFS_W-1:0]  ofs_act  [3];
  logic signed [OFS_W-1:0]  ofs_nx   [3];
  logic                     mode_sh, mode_act, mode_nx;
  logic                     vsync_prev, vsync_edge, cfg_hit, cfg_pending_r;

  assign vsync_edge = bus.vsync_in & ~vsync_prev;
  assign cfg_hit    = bus.cfg_we & (bus.cfg_addr <= 4'd12);

  // Shadow bank with the current write merged in, so an edge-cycle write is applied too.
  always_comb begin
    for (int i = 0; i < 9; i++) coef_nx[i] = coef_sh[i];
    for (int i = 0; i < 3; i++) ofs_nx[i]  = ofs_sh[i];
    mode_nx = mode_sh;
    if (cfg_hit) begin
      if (bus.cfg_addr <= 4'd8)
        coef_nx[bus.cfg_addr] = bus.cfg_data;
      else if (bus.cfg_addr <= 4'd11)
        ofs_nx[bus.cfg_addr - 4'd9] = bus.cfg_data[OFS_W-1:0];
      else
        mode_nx = bus.cfg_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        coef_sh[i]  <= dflt_coef(i);
        coef_act[i] <= dflt_coef(i);
      end
      for (int i = 0; i < 3; i++) begin
        ofs_sh[i]  <= dflt_ofs(i);
        ofs_act[i] <= dflt_ofs(i);
      end
      mode_sh       <= 1'b1;
      mode_act      <= 1'b1;
      vsync_prev    <= 1'b0;
      cfg_pending_r <= 1'b0;
    end else begin
      coef_sh    <= coef_nx;
      ofs_sh     <= ofs_nx;
      mode_sh    <= mode_nx;
      vsync_prev <= bus.vsync_in;
      if (vsync_edge) begin
        coef_act      <= coef_nx;
        ofs_act       <= ofs_nx;
        mode_act      <= mode_nx;
        cfg_pending_r <= 1'b0;
      end else if (cfg_hit) begin
        cfg_pending_r <= 1'b1;
      end
    end
  end

  assign bus.cfg_pending = cfg_pending_r;

  logic [PIX_W-1:0]         pix_p1, pix_p2, pix_p3, pix_p4;
  logic [2:0]               sync_p1, sync_p2, sync_p3, sync_p4;
  logic                     mode_p1, mode_p2, mode_p3;
  logic signed [PROD_W-1:0] prod_p2 [9];
  logic signed [ACC_W-1:0]  acc_p3  [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_p1 <= '0; pix_p2 <= '0; pix_p3 <= '0; pix_p4 <= '0;
      sync_p1 <= '0; sync_p2 <= '0; sync_p3 <= '0; sync_p4 <= '0;
      mode_p1 <= 1'b0; mode_p2 <= 1'b0; mode_p3 <= 1'b0;
      for (int i = 0; i < 9; i++) prod_p2[i] <= '0;
      for (int i = 0; i < 3; i++) acc_p3[i]  <= '0;
    end else begin
      // S1: capture pixel, syncs and the live mode
      pix_p1  <= bus.pixel_in;
      sync_p1 <= {bus.de_in, bus.hsync_in, bus.vsync_in};
      mode_p1 <= mode_act;
      // S2: nine products, components zero-extended into signed operands
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          prod_p2[3*r+c] <= PROD_W'($signed({1'b0, pix_p1[PIX_W-1-c*DATA_W -: DATA_W]}))
                            * PROD_W'(coef_act[3*r+c]);
      pix_p2  <= pix_p1;
      sync_p2 <= sync_p1;
      mode_p2 <= mode_p1;
      // S3: row sums plus offset and half-LSB rounding
      for (int r = 0; r < 3; r++)
        acc_p3[r] <= round_acc(ACC_W'(prod_p2[3*r]) + ACC_W'(prod_p2[3*r+1])
                               + ACC_W'(prod_p2[3*r+2]) + (ACC_W'(ofs_act[r]) <<< FRAC_W));
      pix_p3  <= pix_p2;
      sync_p3 <= sync_p2;
      mode_p3 <= mode_p2;
      // S4: scale back, clamp, or pass the original pixel in bypass
      for (int r = 0; r < 3; r++)
        pix_p4[PIX_W-1-r*DATA_W -: DATA_W] <= mode_p3 ? sat_pix(acc_p3[r])
                                                      : pix_p3[PIX_W-1-r*DATA_W -: DATA_W];
      sync_p4 <= sync_p3;
    end
  end

  assign bus.pixel_out = pix_p4;
  assign bus.de_out    = sync_p4[2];
  assign bus.hsync_out = sync_p4[1];
  assign bus.vsync_out = sync_p4[0];
endmodule

// File: doc/rgb2ycbcr_csc.md
Name: rgb2ycbcr_csc

Overview:
Parametrised, run-time-programmable 3x3 colour-space converter for the video pixel path: RGB in, three converted components out, plus per-channel offset, round-to-nearest and clamping.
Coefficients, offsets and mode are written through a simple register port into a shadow bank. The shadow bank is applied to the live datapath only at a frame boundary, so one frame never mixes two coefficient sets.
Sits between the video source and downstream chroma processing. de/hsync/vsync are carried through with the same latency as the pixel data.

Parameters:
DATA_W, 8, bits per colour component in and out
COEF_W, 18, signed coefficient width (two's complement)
FRAC_W, 16, fractional bits of coefficients (1.0 = 2^FRAC_W)

Ports:
clk  in  1  pixel clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
de_in  in  1  data enable
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync; a rising edge marks the frame boundary
pixel_in  in  3*DATA_W  {R,G,B}, unsigned, R in the MSBs
de_out  out  1  de_in delayed by 4 cycles
hsync_out  out  1  hsync_in delayed by 4 cycles
vsync_out  out  1  vsync_in delayed by 4 cycles
pixel_out  out  3*DATA_W  {C0,C1,C2} unsigned (Y,Cb,Cr in default set), C0 in the MSBs
cfg_we  in  1  shadow register write strobe
cfg_addr  in  4  0-8: matrix entry row-major (row = output channel, column = R,G,B); 9-11: offset C0-C2; 12: mode; 13-15: ignored
cfg_data  in  COEF_W  write data; offsets use the low DATA_W+2 bits, sign-extended; mode uses bit 0
cfg_pending  out  1  high while the shadow bank holds writes not yet applied

Behaviour:
- Reset (rst=1 at a clock edge):
  - pixel_out=0; de_out/hsync_out/vsync_out=0; all pipeline stages cleared; cfg_pending=0.
  - Shadow and active banks both load BT.601 full-range defaults (FRAC_W=16 values): row0 19595,38470,7471; row1 -11059,-21709,32768; row2 32768,-27439,-5329.
  - Default offsets 0, 128<<(DATA_W-8), 128<<(DATA_W-8). Default mode=1 (convert).
  - The previous-vsync register is cleared to 0.
- Register writes:
  - cfg_we=1 writes cfg_data to the shadow entry at cfg_addr and sets cfg_pending. Writes to addresses 13-15 do nothing and do not set cfg_pending.
- Frame-boundary apply:
  - A vsync edge is detected when vsync_in=1 and the registered previous vsync_in=0.
  - On that cycle the active bank <= shadow bank and cfg_pending clears.
  - If a write coincides with the edge, the written value is included in the applied bank and cfg_pending ends the cycle at 0.
  - The active bank changes on no other cycle.
- Pipeline, fixed latency 4 in both modes (pixel and syncs stay aligned):
  - S1: register the input pixel and syncs.
  - S2: nine signed products, each operand zero-extended to DATA_W+1 bits, times its coefficient; registered.
  - S3: per channel acc = p0+p1+p2 + (offset<<FRAC_W) + 2^(FRAC_W-1); acc is signed, DATA_W+COEF_W+3 bits; registered.
  - S4: v = acc >>> FRAC_W (arithmetic shift); clamp to [0, 2^DATA_W-1]; registered to pixel_out.
- Mode 0 (bypass): pixel_out = pixel_in delayed by 4 cycles, unmodified. Mode is sampled with the pixel at S1.
- Pixels are processed on every cycle regardless of de_in; de only travels with the data.
- Reset mid-frame: the pipeline flushes to zeros immediately, and pending shadow writes are discarded (defaults reloaded).

Test Plan:
- Reset, then pixel_in=FFFFFF for one cycle with de_in=1 -> 4 cycles later pixel_out={255,128,128} and de_out=1 on that same cycle; before that pixel_out=0.
- pixel_in=FF0000 -> Y=76, Cb=85, Cr clamped 256->255. pixel_in=0000FF -> Y=29, Cb clamped 255, Cr=107.
- Write offset C1 (addr 10) = 0 mid-frame -> cfg_pending=1 and output still uses 128. Raise vsync_in -> cfg_pending=0 the next cycle. Then pixel FF0000 -> Cb clamps to 0.
- cfg_we with addr 12, data 0 on the same cycle as a vsync rising edge -> cfg_pending stays 0; pixel 123456 appears unchanged 4 cycles later.
- Hold vsync_in=1 for 10 cycles and write addr 0 during that time -> no apply until vsync falls and rises again.
- Continuous random RGB stream with toggling de/hsync/vsync vs golden model -> bit-exact pixel_out and syncs at latency 4. Assert rst mid-stream -> all outputs 0 the next cycle, cfg_pending=0.
